// File: rtl/wb_arbiter.sv
// Writeback arbiter: serialises ALU/load/FPU results onto the single register-file
// write port and tracks GPR/FPR busy bits. Define WB_RR_EN for round-robin arbitration.
module wb_arbiter #(
    parameter int NSRC   = 3,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NSRC-1:0]          src_valid,
    output logic [NSRC-1:0]          src_ready,
    input  logic [2*NSRC-1:0]        src_rw,
    input  logic [5*NSRC-1:0]        src_rd,
    input  logic [DATA_W*NSRC-1:0]   src_data,
    output logic [1:0]               rwin,
    output logic [4:0]               rdin,
    output logic [DATA_W-1:0]        dtowrite,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_rw,
    input  logic [4:0]               issue_rd,
    output logic [31:0]              gpr_busy,
    output logic [31:0]              fpr_busy
);

    typedef struct packed {
        logic [1:0]        rw;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    wb_req_t req [NSRC];

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign req[i] = '{rw: src_rw[i*2 +: 2], rd: src_rd[i*5 +: 5], data: src_data[i*DATA_W +: DATA_W]};
    end

    // base = first index searched; fixed priority 1>2>0 is the round-robin order with pointer 0
    logic [1:0] base;
    logic [1:0] sel;
    logic       gnt;
    logic [2:0] idx;

`ifdef WB_RR_EN
    logic [1:0] rr_ptr;

    assign base = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    rr_ptr <= 2'd0;
        else if (gnt) rr_ptr <= sel;
    end
`else
    assign base = 2'd1;
`endif

    always_comb begin
        gnt       = 1'b0;
        sel       = 2'd0;
        idx       = 3'd0;
        src_ready = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = {1'b0, base} + 3'(k);
            if (idx >= 3'(NSRC)) idx = idx - 3'(NSRC);
            if (!gnt && src_valid[idx[1:0]]) begin
                gnt = 1'b1;
                sel = idx[1:0];
            end
        end
        if (gnt) src_ready[sel] = 1'b1;
    end

    // Filtered writes (rw=11, GPR 0) still take their slot but present rwin=00
    wb_req_t    win;
    logic [1:0] wr_rw;

    assign win = req[sel];

    always_comb begin
        wr_rw = 2'b00;
        if (win.rw == 2'b10)                          wr_rw = 2'b10;
        else if (win.rw == 2'b01 && win.rd != 5'd0)   wr_rw = 2'b01;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rwin     <= 2'b00;
            rdin     <= 5'd0;
            dtowrite <= '0;
        end else if (gnt) begin
            rwin     <= wr_rw;
            rdin     <= win.rd;
            dtowrite <= win.data;
        end else begin
            rwin     <= 2'b00;
        end
    end

    logic [31:0] gpr_set, fpr_set, gpr_clr, fpr_clr;

    always_comb begin
        gpr_set = '0;
        fpr_set = '0;
        gpr_clr = '0;
        fpr_clr = '0;
        if (issue_valid && issue_rw == 2'b01 && issue_rd != 5'd0) gpr_set[issue_rd] = 1'b1;
        if (issue_valid && issue_rw == 2'b10)                     fpr_set[issue_rd] = 1'b1;
        if (rwin == 2'b01) gpr_clr[rdin] = 1'b1;
        if (rwin == 2'b10) fpr_clr[rdin] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-bit re-issue keeps the bit busy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpr_busy <= '0;
            fpr_busy <= '0;
        end else begin
            gpr_busy <= (gpr_busy & ~gpr_clr) | gpr_set;
            fpr_busy <= (fpr_busy & ~fpr_clr) | fpr_set;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed table, hand-written corner sequences and a
// randomized run against a behavioural model of the writeback rules.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [5:0]  src_rw;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic [1:0]  rwin;
    logic [4:0]  rdin;
    logic [31:0] dtowrite;
    logic        issue_valid;
    logic [1:0]  issue_rw;
    logic [4:0]  issue_rd;
    logic [31:0] gpr_busy;
    logic [31:0] fpr_busy;

    wb_arbiter dut (
        .clk(clk), .rstn(rstn),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rw(src_rw), .src_rd(src_rd), .src_data(src_data),
        .rwin(rwin), .rdin(rdin), .dtowrite(dtowrite),
        .issue_valid(issue_valid), .issue_rw(issue_rw), .issue_rd(issue_rd),
        .gpr_busy(gpr_busy), .fpr_busy(fpr_busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [1:0] rw, input logic [4:0] rd, input logic [31:0] d);
        src_valid[i]       = v;
        src_rw[i*2 +: 2]   = rw;
        src_rd[i*5 +: 5]   = rd;
        src_data[i*32 +: 32] = d;
    endtask

    task automatic idle;
        src_valid   = '0;
        issue_valid = 1'b0;
        issue_rw    = 2'b00;
        issue_rd    = 5'd0;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        idle();
        src_rw   = '0;
        src_rd   = '0;
        src_data = '0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    typedef struct {
        int          src;
        logic [1:0]  rw;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [2:0]  ready;
        logic [1:0]  rwin;
    } vec_t;

    vec_t tbl [7];

    // behavioural model state
    logic [1:0]  m_rwin;
    logic [4:0]  m_rdin;
    logic [31:0] m_data;
    bit          mg [32];
    bit          mf [32];
    logic [31:0] pg, pf;
    int          last, g, s;
    int          prio [3];
    logic [2:0]  exp_rdy;
    logic [1:0]  rw_g;
    logic [4:0]  rd_g;
    int          ord [3];
    logic [4:0]  ord_rd [3];
    logic [1:0]  ord_rw [3];

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{0, 2'b01, 5'd5,  32'h0000_1234, 3'b001, 2'b01};
        tbl[1] = '{0, 2'b01, 5'd0,  32'h0000_FFFF, 3'b001, 2'b00};
        tbl[2] = '{0, 2'b11, 5'd9,  32'h0000_0099, 3'b001, 2'b00};
        tbl[3] = '{2, 2'b10, 5'd0,  32'h0000_CAFE, 3'b100, 2'b10};
        tbl[4] = '{1, 2'b01, 5'd31, 32'hDEAD_BEEF, 3'b010, 2'b01};
        tbl[5] = '{2, 2'b00, 5'd4,  32'h0000_0044, 3'b100, 2'b00};
        tbl[6] = '{1, 2'b10, 5'd12, 32'h1200_0012, 3'b010, 2'b10};

        // reset state, including while reset is still asserted
        rstn = 1'b0;
        idle();
        src_rw = '0; src_rd = '0; src_data = '0;
        #2;
        check("rst_rwin_low", rwin, 2'b00);
        do_reset();
        check("rst_rwin", rwin, 2'b00);
        check("rst_rdin", rdin, 5'd0);
        check("rst_dtowrite", dtowrite, 32'd0);
        check("rst_gpr_busy", gpr_busy, 32'd0);
        check("rst_fpr_busy", fpr_busy, 32'd0);
        check("rst_ready", src_ready, 3'b000);

        // single-source vectors
        for (int t = 0; t < 7; t++) begin
            idle();
            set_src(tbl[t].src, 1'b1, tbl[t].rw, tbl[t].rd, tbl[t].d);
            #1;
            check($sformatf("tbl%0d_ready", t), src_ready, tbl[t].ready);
            tick();
            idle();
            check($sformatf("tbl%0d_rwin", t), rwin, tbl[t].rwin);
            if (tbl[t].rwin != 2'b00) begin
                check($sformatf("tbl%0d_rdin", t), rdin, tbl[t].rd);
                check($sformatf("tbl%0d_data", t), dtowrite, tbl[t].d);
            end
            tick();
            check($sformatf("tbl%0d_idle_rwin", t), rwin, 2'b00);
            if (tbl[t].rwin != 2'b00) begin
                check($sformatf("tbl%0d_hold_rdin", t), rdin, tbl[t].rd);
                check($sformatf("tbl%0d_hold_data", t), dtowrite, tbl[t].d);
            end
        end

        // all three valid together: order 1, 2, 0 from reset in both arbitration modes
        do_reset();
        set_src(0, 1'b1, 2'b01, 5'd1, 32'hA0);
        set_src(1, 1'b1, 2'b01, 5'd2, 32'hA1);
        set_src(2, 1'b1, 2'b10, 5'd3, 32'hA2);
        ord = '{1, 2, 0};
        ord_rw = '{2'b01, 2'b10, 2'b01};
        ord_rd = '{5'd2, 5'd3, 5'd1};
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("all3_ready%0d", k), src_ready, 3'b001 << ord[k]);
            tick();
            src_valid[ord[k]] = 1'b0;
            check($sformatf("all3_rwin%0d", k), rwin, ord_rw[k]);
            check($sformatf("all3_rdin%0d", k), rdin, ord_rd[k]);
        end
        tick();
        check("all3_after_rwin", rwin, 2'b00);

        // after src0 was last served, src1 and src2 together: 1 before 2
        set_src(1, 1'b1, 2'b01, 5'd20, 32'hB1);
        set_src(2, 1'b1, 2'b01, 5'd21, 32'hB2);
        #1;
        check("re_ready_a", src_ready, 3'b010);
        tick();
        src_valid[1] = 1'b0;
        #1;
        check("re_ready_b", src_ready, 3'b100);
        tick();
        src_valid[2] = 1'b0;
        check("re_rdin_b", rdin, 5'd21);

        // scoreboard: FPR set, cleared by the write, gone from N+2
        do_reset();
        issue_valid = 1'b1; issue_rw = 2'b10; issue_rd = 5'd7;
        tick();
        idle();
        check("sb_fpr_set", fpr_busy, 32'h80);
        check("sb_gpr_untouched", gpr_busy, 32'h0);
        set_src(2, 1'b1, 2'b10, 5'd7, 32'hF7);
        #1;
        check("sb_fpu_ready", src_ready, 3'b100);
        tick();
        idle();
        check("sb_wr_rwin", rwin, 2'b10);
        check("sb_busy_n1", fpr_busy, 32'h80);
        tick();
        check("sb_busy_n2", fpr_busy, 32'h0);

        // re-issue of FPR 7 on the same edge as its clear: set wins
        issue_valid = 1'b1; issue_rw = 2'b10; issue_rd = 5'd7;
        tick();
        idle();
        set_src(2, 1'b1, 2'b10, 5'd7, 32'hF8);
        tick();
        idle();
        issue_valid = 1'b1; issue_rw = 2'b10; issue_rd = 5'd7;
        tick();
        idle();
        check("sb_set_wins", fpr_busy, 32'h80);
        tick();
        check("sb_set_holds", fpr_busy, 32'h80);

        // GPR 0 never set; rw=11 issue ignored
        issue_valid = 1'b1; issue_rw = 2'b01; issue_rd = 5'd0;
        tick();
        issue_rw = 2'b11; issue_rd = 5'd4;
        tick();
        idle();
        check("sb_gpr0", gpr_busy, 32'h0);
        check("sb_rw11_fpr", fpr_busy, 32'h80);

        // clear of GPR 3 and set of GPR 9 on one edge
        issue_valid = 1'b1; issue_rw = 2'b01; issue_rd = 5'd3;
        tick();
        idle();
        check("sb_gpr3", gpr_busy, 32'h8);
        set_src(0, 1'b1, 2'b01, 5'd3, 32'h33);
        tick();
        idle();
        issue_valid = 1'b1; issue_rw = 2'b01; issue_rd = 5'd9;
        tick();
        idle();
        check("sb_set_clr_diff", gpr_busy, 32'h200);

`ifndef WB_RR_EN
        // src0 starved by src1 for four cycles, then served
        do_reset();
        set_src(0, 1'b1, 2'b01, 5'd6, 32'h600D);
        for (int c = 0; c < 4; c++) begin
            set_src(1, 1'b1, 2'b01, 5'(10 + c), 32'(c));
            #1;
            check($sformatf("hold_ready%0d", c), src_ready, 3'b010);
            tick();
            src_valid[1] = 1'b0;
            check($sformatf("hold_rdin%0d", c), rdin, 5'(10 + c));
        end
        #1;
        check("hold_src0_ready", src_ready, 3'b001);
        tick();
        src_valid[0] = 1'b0;
        check("hold_src0_rwin", rwin, 2'b01);
        check("hold_src0_rdin", rdin, 5'd6);
        check("hold_src0_data", dtowrite, 32'h600D);
`endif

        // reset asserted while a write is on the port
        do_reset();
        set_src(0, 1'b1, 2'b01, 5'd8, 32'h88);
        issue_valid = 1'b1; issue_rw = 2'b01; issue_rd = 5'd8;
        tick();
        idle();
        check("midrst_pre_rwin", rwin, 2'b01);
        check("midrst_pre_busy", gpr_busy, 32'h100);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_rwin", rwin, 2'b00);
        check("midrst_busy", gpr_busy, 32'h0);
        tick();
        rstn = 1'b1;

        // randomized run against the model
        do_reset();
        m_rwin = 2'b00; m_rdin = 5'd0; m_data = 32'd0; last = 0;
        for (int i = 0; i < 32; i++) begin mg[i] = 1'b0; mf[i] = 1'b0; end
        prio = '{1, 2, 0};
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++)
                if (!src_valid[i] && $urandom_range(0, 99) < 45)
                    set_src(i, 1'b1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom);
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_rw    = 2'($urandom_range(0, 3));
            issue_rd    = 5'($urandom_range(0, 7));
            g = -1;
            for (int k = 0; k < 3; k++) begin
`ifdef WB_RR_EN
                s = (last + 1 + k) % 3;
`else
                s = prio[k];
`endif
                if (g < 0 && src_valid[s]) g = s;
            end
            exp_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
            #1;
            check("rnd_ready", src_ready, exp_rdy);
            if (m_rwin == 2'b01) mg[m_rdin] = 1'b0;
            if (m_rwin == 2'b10) mf[m_rdin] = 1'b0;
            if (issue_valid && issue_rw == 2'b01 && issue_rd != 5'd0) mg[issue_rd] = 1'b1;
            if (issue_valid && issue_rw == 2'b10) mf[issue_rd] = 1'b1;
            if (g >= 0) begin
                rw_g   = src_rw[g*2 +: 2];
                rd_g   = src_rd[g*5 +: 5];
                m_rwin = (rw_g == 2'b10) ? 2'b10 : (rw_g == 2'b01 && rd_g != 5'd0) ? 2'b01 : 2'b00;
                m_rdin = rd_g;
                m_data = src_data[g*32 +: 32];
                last   = g;
            end else begin
                m_rwin = 2'b00;
            end
            tick();
            if (g >= 0) src_valid[g] = 1'b0;
            for (int i = 0; i < 32; i++) begin pg[i] = mg[i]; pf[i] = mf[i]; end
            check("rnd_rwin", rwin, m_rwin);
            if (m_rwin != 2'b00) begin
                check("rnd_rdin", rdin, m_rdin);
                check("rnd_data", dtowrite, m_data);
            end
            check("rnd_gpr_busy", gpr_busy, pg);
            check("rnd_fpr_busy", fpr_busy, pf);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
